// File: rtl/t09_sound_pkg.sv
// t09_sound_pkg: shared state encoding, default tone/duration tables and the 10 MHz tick divisor
// for the sound sequencer.
package t09_sound_pkg;
  typedef enum logic [1:0] {IDLE, NOTE1, NOTE2, GAP} state_e;
  localparam int TICK_DIV_10MHZ = 10000;
  localparam logic [23:0] DEF_FREQ_TABLE  = {8'd149, 8'd126, 8'd89};
  localparam logic [23:0] DEF_DUR_TABLE   = {8'd20, 8'd200, 8'd50};
  localparam logic [23:0] DEF_FREQ2_TABLE = {8'd0, 8'd63, 8'd178};
endpackage

// File: rtl/t09_tick_gen.sv
// t09_tick_gen: prescaler counting 0..TICK_DIV-1 with synchronous clear; tick_o pulses at terminal count.
module t09_tick_gen
  import t09_sound_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_10MHZ
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick_o = cnt_q == CW'(TICK_DIV - 1);
    cnt_d  = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/t09_sound_sequencer.sv
// t09_sound_sequencer: priority-arbitrated event tone player with pending buffer and silent gaps.
// Define T09_SOUND_DUAL_TONE_EN to add a second note (FREQ2_TABLE) after each first note.
module t09_sound_sequencer
  import t09_sound_pkg::*;
#(
  parameter int NUM_EVENTS = 3,
  parameter int FREQ_W     = 8,
  parameter int DUR_W      = 8,
  parameter int TICK_DIV   = TICK_DIV_10MHZ,
  parameter int GAP_TICKS  = 5,
  parameter logic [NUM_EVENTS*FREQ_W-1:0] FREQ_TABLE = DEF_FREQ_TABLE,
  parameter logic [NUM_EVENTS*DUR_W-1:0]  DUR_TABLE  = DEF_DUR_TABLE
`ifdef T09_SOUND_DUAL_TONE_EN
  , parameter logic [NUM_EVENTS*FREQ_W-1:0] FREQ2_TABLE = DEF_FREQ2_TABLE
`endif
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          en_i,
  input  logic [NUM_EVENTS-1:0]         event_i,
  output logic [FREQ_W-1:0]             freq_o,
  output logic                          busy_o,
  output logic [$clog2(NUM_EVENTS)-1:0] cur_evt_o
);
  localparam int IW = $clog2(NUM_EVENTS);
  localparam logic [DUR_W-1:0] GAP_DUR = DUR_W'(GAP_TICKS > 0 ? GAP_TICKS : 1);
  state_e state_q, state_d;
  logic [IW-1:0] cur_q, cur_d, hi, pk;
  logic [NUM_EVENTS-1:0] pend_q, pend_d, pend_n, le_mask;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic clr, tick, note, done;
  function automatic logic [IW-1:0] msb(input logic [NUM_EVENTS-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_EVENTS; i++) if (v[i]) r = IW'(i);
    return r;
  endfunction
  function automatic logic [NUM_EVENTS-1:0] bit_of(input logic [IW-1:0] i);
    return NUM_EVENTS'(1) << i;
  endfunction
  function automatic logic [FREQ_W-1:0] freq_of(input logic [IW-1:0] i);
    return FREQ_TABLE[int'(i)*FREQ_W +: FREQ_W];
  endfunction
`ifdef T09_SOUND_DUAL_TONE_EN
  function automatic logic [FREQ_W-1:0] freq2_of(input logic [IW-1:0] i);
    return FREQ2_TABLE[int'(i)*FREQ_W +: FREQ_W];
  endfunction
`endif
  function automatic logic [DUR_W-1:0] dur_of(input logic [IW-1:0] i);
    logic [DUR_W-1:0] d;
    d = DUR_TABLE[int'(i)*DUR_W +: DUR_W];
    return d == '0 ? DUR_W'(1) : d;
  endfunction
  t09_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .nrst  (nrst),
    .clr_i (clr),
    .tick_o(tick)
  );
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    dur_d   = dur_q;
    freq_d  = freq_q;
    clr     = 1'b0;
    hi      = msb(event_i);
    for (int i = 0; i < NUM_EVENTS; i++) le_mask[i] = i <= int'(cur_q);
    note    = state_q == NOTE1 || state_q == NOTE2;
    done    = tick && dur_q <= DUR_W'(1);
    // a held level of the playing event must not queue a replay of itself
    pend_n  = pend_q | (event_i & le_mask & ~({NUM_EVENTS{note}} & bit_of(cur_q)));
    pk      = msb(pend_n);
    if (!en_i) begin
      state_d = IDLE;
      freq_d  = '0;
      pend_d  = '0;
      dur_d   = '0;
      clr     = 1'b1;
    end else if (state_q == IDLE ? |event_i : |(event_i & ~le_mask)) begin
      state_d = NOTE1;
      cur_d   = hi;
      freq_d  = freq_of(hi);
      dur_d   = dur_of(hi);
      pend_d  = pend_q | (event_i & ~bit_of(hi));
      clr     = 1'b1;
    end else if (state_q != IDLE) begin
      pend_d = pend_n;
      if (tick) dur_d = dur_q - 1'b1;
      if (done) begin
        clr = 1'b1;
        if (state_q == GAP) begin
          state_d = NOTE1;
          freq_d  = freq_of(cur_q);
          dur_d   = dur_of(cur_q);
        end
`ifdef T09_SOUND_DUAL_TONE_EN
        else if (state_q == NOTE1 && freq2_of(cur_q) != '0) begin
          state_d = NOTE2;
          freq_d  = freq2_of(cur_q);
          dur_d   = dur_of(cur_q);
        end
`endif
        else if (|pend_n) begin
          state_d = GAP;
          cur_d   = pk;
          freq_d  = '0;
          dur_d   = GAP_DUR;
          pend_d  = pend_n & ~bit_of(pk);
        end else begin
          state_d = IDLE;
          freq_d  = '0;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      pend_q  <= '0;
      dur_q   <= '0;
      freq_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      dur_q   <= dur_d;
      freq_q  <= freq_d;
    end
  assign freq_o    = freq_q;
  assign busy_o    = state_q != IDLE;
  assign cur_evt_o = cur_q;
endmodule

// File: tb/tb_t09_sound_sequencer.sv
// tb_t09_sound_sequencer: scoreboard bench; expected tone segments are queued per scenario and
// compared against run-length segments observed on freq_o/cur_evt_o until busy_o drops.
module tb_t09_sound_sequencer;
  logic clk = 1'b0, nrst = 1'b0, en_i = 1'b0;
  logic [2:0] event_i = 3'b000;
  logic [7:0] freq_o;
  logic busy_o;
  logic [1:0] cur_evt_o;
  int errors = 0, checks = 0, end_f, ncyc;
  typedef struct {int f; int n; int c;} seg_t;
  seg_t exp_q[$], obs_q[$];
  int tf[3]  = '{89, 126, 149};
  int tf2[3] = '{178, 63, 0};
  int tn[3]  = '{200, 800, 80};

  always #5 clk = ~clk;

  t09_sound_sequencer #(.TICK_DIV(4)) dut (
    .clk(clk), .nrst(nrst), .en_i(en_i), .event_i(event_i),
    .freq_o(freq_o), .busy_o(busy_o), .cur_evt_o(cur_evt_o)
  );

  task automatic push_note(input int e);
    exp_q.push_back('{tf[e], tn[e], e});
`ifdef T09_SOUND_DUAL_TONE_EN
    if (tf2[e] != 0) exp_q.push_back('{tf2[e], tn[e], e});
`endif
  endtask

  task automatic push_gap(input int c);
    exp_q.push_back('{0, 20, c});
  endtask

  // records run-length segments; ev2 is driven so that it is sampled at edge k
  task automatic collect(input logic [2:0] ev2, input int k);
    seg_t s;
    bit open = 0;
    obs_q = {};
    ncyc = -1;
    end_f = -1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!busy_o) begin
        end_f = int'(freq_o);
        ncyc = n;
        break;
      end
      if (open && s.f == int'(freq_o) && s.c == int'(cur_evt_o)) s.n++;
      else begin
        if (open) obs_q.push_back(s);
        s = '{int'(freq_o), 1, int'(cur_evt_o)};
        open = 1;
      end
      event_i = (n + 1 == k) ? ev2 : 3'b000;
    end
    if (open) obs_q.push_back(s);
    event_i = 3'b000;
  endtask

  task automatic test_pattern(input string name, input logic [2:0] ev1, input logic [2:0] ev2, input int k);
    seg_t e, o;
    int i = 0;
    @(negedge clk);
    event_i = ev1;
    collect(ev2, k);
    checks++;
    if (ncyc < 0) begin errors++; $display("FAIL %s timeout: busy_o never fell", name); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s segment count: got %0d exp %0d", name, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks += 3;
      if (o.f !== e.f) begin errors++; $display("FAIL %s seg%0d freq: got %0d exp %0d", name, i, o.f, e.f); end
      if (o.n !== e.n) begin errors++; $display("FAIL %s seg%0d length: got %0d exp %0d", name, i, o.n, e.n); end
      if (o.c !== e.c) begin errors++; $display("FAIL %s seg%0d cur_evt: got %0d exp %0d", name, i, o.c, e.c); end
      i++;
    end
    exp_q = {};
    checks++;
    if (end_f !== 0) begin errors++; $display("FAIL %s idle freq: got %0d exp 0", name, end_f); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 3;
    if (freq_o !== 8'd0) begin errors++; $display("FAIL reset freq_o: got %0d exp 0", freq_o); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset busy_o: got %0d exp 0", busy_o); end
    if (cur_evt_o !== 2'd0) begin errors++; $display("FAIL reset cur_evt_o: got %0d exp 0", cur_evt_o); end
    nrst = 1'b1;
    en_i = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    push_note(0);
    test_pattern("single", 3'b001, 3'b000, 0);
  endtask

  task automatic test_preempt();
    exp_q.push_back('{89, 20, 0});
    push_note(2);
    test_pattern("preempt", 3'b001, 3'b100, 20);
  endtask

  task automatic test_gap();
    push_note(2);
    push_gap(1);
    push_note(1);
    test_pattern("gap", 3'b100, 3'b010, 8);
  endtask

  task automatic test_all();
    push_note(2);
    push_gap(1);
    push_note(1);
    push_gap(0);
    push_note(0);
    test_pattern("all", 3'b111, 3'b000, 0);
  endtask

  task automatic test_enable();
    @(negedge clk) event_i = 3'b100;
    @(negedge clk) event_i = 3'b010;
    @(negedge clk) event_i = 3'b000;
    repeat (5) @(negedge clk);
    checks += 2;
    if (freq_o !== 8'd149) begin errors++; $display("FAIL en_pre freq_o: got %0d exp 149", freq_o); end
    if (busy_o !== 1'b1) begin errors++; $display("FAIL en_pre busy_o: got %0d exp 1", busy_o); end
    en_i = 1'b0;
    @(negedge clk);
    checks += 2;
    if (freq_o !== 8'd0) begin errors++; $display("FAIL en_low freq_o: got %0d exp 0", freq_o); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL en_low busy_o: got %0d exp 0", busy_o); end
    event_i = 3'b001;
    repeat (5) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL en_ignore busy_o: got %0d exp 0", busy_o); end
    event_i = 3'b000;
    en_i = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL en_resume busy_o: got %0d exp 0", busy_o); end
    push_note(2);
    test_pattern("after_en", 3'b100, 3'b000, 0);
  endtask

  task automatic test_async_reset();
    @(negedge clk) event_i = 3'b010;
    @(negedge clk) event_i = 3'b000;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    checks += 3;
    if (freq_o !== 8'd0) begin errors++; $display("FAIL async_rst freq_o: got %0d exp 0", freq_o); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL async_rst busy_o: got %0d exp 0", busy_o); end
    if (cur_evt_o !== 2'd0) begin errors++; $display("FAIL async_rst cur_evt_o: got %0d exp 0", cur_evt_o); end
    @(negedge clk) nrst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_preempt();
    test_gap();
    test_all();
    test_enable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
